// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath: default image geometry,
// pixel type and window size used by both the window generator and the conv core.
package conv_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_WIDTH_DEF  = 28;
    localparam int IMG_HEIGHT_DEF = 28;
    localparam int K              = 3;

    typedef logic signed [DATA_WIDTH_DEF-1:0] pixel_t;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Single-row line buffer: one address per access, returns the old contents of
// that address while the new pixel is written (read-before-write).
module line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = IMG_WIDTH_DEF,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Row storage write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster pixel stream into 3x3 windows for the convolution core, using
// two chained line buffers for the previous rows and a 3x3 shift register.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] p00,
    output logic [DATA_WIDTH-1:0] p01,
    output logic [DATA_WIDTH-1:0] p02,
    output logic [DATA_WIDTH-1:0] p10,
    output logic [DATA_WIDTH-1:0] p11,
    output logic [DATA_WIDTH-1:0] p12,
    output logic [DATA_WIDTH-1:0] p20,
    output logic [DATA_WIDTH-1:0] p21,
    output logic [DATA_WIDTH-1:0] p22,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  frame_done
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] win_q [K][K];
    logic [DATA_WIDTH-1:0] win_d [K][K];
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [ROW_W-1:0]      out_row_q, out_row_d;
    logic [COL_W-1:0]      out_col_q, out_col_d;
    logic [DATA_WIDTH-1:0] tap1_s, tap2_s;
    logic                  lb_we_s;

    // A pixel presented while in reset belongs to no frame, so keep it out of the rows
    assign lb_we_s = valid_in & ~rst;

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .we_i    (lb_we_s),
        .addr_i  (col_q),
        .wdata_i (pixel_in),
        .rdata_o (tap1_s)
    );

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb2 (
        .clk     (clk),
        .we_i    (lb_we_s),
        .addr_i  (col_q),
        .wdata_i (tap1_s),
        .rdata_o (tap2_s)
    );

    // Next-state: raster counters, window shift and output qualification
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        if (valid_in) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][K-1] = tap2_s;
            win_d[1][K-1] = tap1_s;
            win_d[2][K-1] = pixel_in;

            if (col_q == COL_LAST) begin
                col_d = {COL_W{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end

            // Columns 0/1 would mix in the tail of the previous row, so they never qualify
            valid_d   = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            done_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
            out_row_d = row_q - ROW_FIRST;
            out_col_d = col_q - COL_FIRST;
        end else begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= {COL_W{1'b0}};
            row_q     <= {ROW_W{1'b0}};
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            out_row_q <= {ROW_W{1'b0}};
            out_col_q <= {COL_W{1'b0}};
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            win_q     <= win_d;
        end
    end

    assign valid_out  = valid_q;
    assign frame_done = done_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign p00        = win_q[0][0];
    assign p01        = win_q[0][1];
    assign p02        = win_q[0][2];
    assign p10        = win_q[1][0];
    assign p11        = win_q[1][1];
    assign p12        = win_q[1][2];
    assign p20        = win_q[2][0];
    assign p21        = win_q[2][1];
    assign p22        = win_q[2][2];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance for window content and
// control scenarios, and a default 28x28 instance for full-frame sweep.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic       rst4, vin4, v4, fd4;
    logic [7:0] pin4;
    logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
    logic [1:0] orow4, ocol4;

    // 28x28 instance
    logic       rst28, vin28, v28, fd28;
    logic [7:0] pin28;
    logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
    logic [4:0] orow28, ocol28;

    conv_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .rst(rst4), .valid_in(vin4), .pixel_in(pin4), .valid_out(v4),
        .p00(a00), .p01(a01), .p02(a02), .p10(a10), .p11(a11), .p12(a12),
        .p20(a20), .p21(a21), .p22(a22), .out_row(orow4), .out_col(ocol4),
        .frame_done(fd4)
    );

    conv_window_gen dut28 (
        .clk(clk), .rst(rst28), .valid_in(vin28), .pixel_in(pin28), .valid_out(v28),
        .p00(b00), .p01(b01), .p02(b02), .p10(b10), .p11(b11), .p12(b12),
        .p20(b20), .p21(b21), .p22(b22), .out_row(orow28), .out_col(ocol28),
        .frame_done(fd28)
    );

    typedef struct packed {
        logic [71:0] px;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        fd;
    } rec_t;

    rec_t q4[$];
    int   total = 0;
    int   bad   = 0;
    int   gap_bad4 = 0;
    logic prev_vin4 = 1'b0;
    int   cnt28 = 0, fd_cnt28 = 0, bad28 = 0, er = 0, ec = 0;

    always @(posedge clk) prev_vin4 = vin4;

    // Window capture for the 4x4 instance, plus checks that outputs only follow accepted pixels
    always @(negedge clk) begin
        if (v4) q4.push_back({{a00, a01, a02, a10, a11, a12, a20, a21, a22}, orow4, ocol4, fd4});
        if ((v4 || fd4) && !prev_vin4) gap_bad4++;
        if (fd4 && !v4) gap_bad4++;
    end

    // Sweep model for the 28x28 instance: expected position and contents of each window
    always @(negedge clk) begin
        if (v28) begin
            if (orow28 !== 5'(er) || ocol28 !== 5'(ec)) bad28++;
            if (b00 !== 8'(er * 28 + ec) || b11 !== 8'((er + 1) * 28 + ec + 1) ||
                b22 !== 8'((er + 2) * 28 + ec + 2)) bad28++;
            if (fd28 !== ((er == 25) && (ec == 25))) bad28++;
            if (fd28) fd_cnt28++;
            cnt28++;
            if (ec == 25) begin ec = 0; er++; end else ec++;
        end else if (fd28) begin
            bad28++;
        end
    end

    function automatic logic [7:0] pix4(input int kind, input int idx);
        case (kind)
            0:       return 8'(idx + 1);
            1:       return 8'(101 + idx);
            default: return 8'(-(idx + 1));
        endcase
    endfunction

    // Expected k-th window (raster order) of a 4x4 frame
    function automatic rec_t exp4(input int kind, input int k);
        rec_t        e;
        logic [71:0] px;
        int          r, c;
        r  = k / 2;
        c  = k % 2;
        px = 72'd0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                px = {px[63:0], pix4(kind, (r + rr) * 4 + c + cc)};
        e.px  = px;
        e.row = 2'(r);
        e.col = 2'(c);
        e.fd  = (k == 3);
        return e;
    endfunction

    task automatic cyc4(input logic v, input logic [7:0] d);
        vin4 = v; pin4 = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            vin4 = 1'b0; vin28 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst4 = 1'b1; rst28 = 1'b1; vin4 = 1'b0; vin28 = 1'b0; pin4 = 8'd0; pin28 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({v4, fd4, orow4, ocol4, a00, a01, a02, a10, a11, a12, a20, a21, a22} !== 78'd0) begin
            bad++;
            $display("FAIL reset4: got %h want 0",
                     {v4, fd4, orow4, ocol4, a00, a01, a02, a10, a11, a12, a20, a21, a22});
        end
        total++;
        if ({v28, fd28, orow28, ocol28, b00, b01, b02, b10, b11, b12, b20, b21, b22} !== 84'd0) begin
            bad++;
            $display("FAIL reset28: got %h want 0",
                     {v28, fd28, orow28, ocol28, b00, b01, b02, b10, b11, b12, b20, b21, b22});
        end
        rst4 = 1'b0; rst28 = 1'b0;
        idle(1);
    endtask

    task automatic test_basic;
        q4.delete(); gap_bad4 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc4(1'b1, pix4(0, i));
            if (i == 9) begin
                total++;
                if (v4 !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", v4); end
            end
            if (i == 10) begin
                total++;
                if ({v4, a00, a22, orow4, ocol4} !== {1'b1, 8'd1, 8'd11, 2'd0, 2'd0}) begin
                    bad++;
                    $display("FAIL first_latency: got %h want %h",
                             {v4, a00, a22, orow4, ocol4}, {1'b1, 8'd1, 8'd11, 2'd0, 2'd0});
                end
            end
        end
        idle(2);
        total++;
        if (q4.size() !== 4) begin bad++; $display("FAIL basic_count: got %0d want 4", q4.size()); end
        for (int k = 0; k < q4.size() && k < 4; k++) begin
            total++;
            if (q4[k] !== exp4(0, k)) begin
                bad++; $display("FAIL basic_win%0d: got %h want %h", k, q4[k], exp4(0, k));
            end
        end
        if (q4.size() > 3) begin
            total++;
            if (q4[3].px !== {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16}) begin
                bad++; $display("FAIL basic_last: got %h want 060708_0a0b0c_0e0f10", q4[3].px);
            end
        end
        total++;
        if (gap_bad4 !== 0) begin bad++; $display("FAIL basic_spurious: got %0d want 0", gap_bad4); end
    endtask

    task automatic test_gaps;
        q4.delete(); gap_bad4 = 0;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) cyc4(1'b0, 8'hEE);
            cyc4(1'b1, pix4(0, i));
        end
        idle(2);
        total++;
        if (q4.size() !== 4) begin bad++; $display("FAIL gaps_count: got %0d want 4", q4.size()); end
        for (int k = 0; k < q4.size() && k < 4; k++) begin
            total++;
            if (q4[k] !== exp4(0, k)) begin
                bad++; $display("FAIL gaps_win%0d: got %h want %h", k, q4[k], exp4(0, k));
            end
        end
        total++;
        if (gap_bad4 !== 0) begin bad++; $display("FAIL gaps_valid: got %0d want 0", gap_bad4); end
    endtask

    task automatic test_back_to_back;
        q4.delete(); gap_bad4 = 0;
        for (int i = 0; i < 16; i++) cyc4(1'b1, pix4(0, i));
        for (int i = 0; i < 16; i++) cyc4(1'b1, pix4(1, i));
        idle(2);
        total++;
        if (q4.size() !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", q4.size()); end
        for (int k = 0; k < q4.size() && k < 8; k++) begin
            total++;
            if (q4[k] !== exp4(k / 4, k % 4)) begin
                bad++; $display("FAIL b2b_win%0d: got %h want %h", k, q4[k], exp4(k / 4, k % 4));
            end
        end
        if (q4.size() > 4) begin
            total++;
            if (q4[4].px !== {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111}) begin
                bad++; $display("FAIL b2b_second_first: got %h want 656667_696a6b_6d6e6f", q4[4].px);
            end
        end
    endtask

    task automatic test_reset_mid;
        q4.delete(); gap_bad4 = 0;
        for (int i = 0; i < 10; i++) cyc4(1'b1, pix4(0, i));
        rst4 = 1'b1;
        cyc4(1'b1, 8'h55);
        cyc4(1'b1, 8'h55);
        total++;
        if ({v4, fd4, orow4, ocol4, a00, a01, a02, a10, a11, a12, a20, a21, a22} !== 78'd0) begin
            bad++;
            $display("FAIL midrst_zero: got %h want 0",
                     {v4, fd4, orow4, ocol4, a00, a01, a02, a10, a11, a12, a20, a21, a22});
        end
        rst4 = 1'b0;
        idle(1);
        q4.delete(); gap_bad4 = 0;
        for (int i = 0; i < 16; i++) cyc4(1'b1, pix4(0, i));
        idle(2);
        total++;
        if (q4.size() !== 4) begin bad++; $display("FAIL midrst_count: got %0d want 4", q4.size()); end
        for (int k = 0; k < q4.size() && k < 4; k++) begin
            total++;
            if (q4[k] !== exp4(0, k)) begin
                bad++; $display("FAIL midrst_win%0d: got %h want %h", k, q4[k], exp4(0, k));
            end
        end
    endtask

    task automatic test_negative;
        q4.delete(); gap_bad4 = 0;
        for (int i = 0; i < 16; i++) cyc4(1'b1, pix4(2, i));
        idle(2);
        total++;
        if (q4.size() !== 4) begin bad++; $display("FAIL neg_count: got %0d want 4", q4.size()); end
        for (int k = 0; k < q4.size() && k < 4; k++) begin
            total++;
            if (q4[k] !== exp4(2, k)) begin
                bad++; $display("FAIL neg_win%0d: got %h want %h", k, q4[k], exp4(2, k));
            end
        end
        if (q4.size() > 0) begin
            total++;
            if ({q4[0].px[71:64], q4[0].px[7:0]} !== {8'hFF, 8'hF5}) begin
                bad++; $display("FAIL neg_first: got %h want fff5", {q4[0].px[71:64], q4[0].px[7:0]});
            end
        end
    endtask

    task automatic test_full_28;
        cnt28 = 0; fd_cnt28 = 0; bad28 = 0; er = 0; ec = 0;
        for (int i = 0; i < 784; i++) begin
            vin28 = 1'b1; pin28 = 8'(i);
            @(posedge clk); #1;
        end
        idle(2);
        total++;
        if (cnt28 !== 676) begin bad++; $display("FAIL full_count: got %0d want 676", cnt28); end
        total++;
        if (fd_cnt28 !== 1) begin bad++; $display("FAIL full_done: got %0d want 1", fd_cnt28); end
        total++;
        if (bad28 !== 0) begin bad++; $display("FAIL full_sweep: got %0d errors want 0", bad28); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gaps;
        test_back_to_back;
        test_reset_mid;
        test_negative;
        test_full_28;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
